// File: rtl/dm_axi_if.sv
// ============================================================================
// Module      : dm_axi_if
// Description : AXI3-style five-channel bundle between the data-memory
//               master and its slave (single 32-bit data lane).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_axi_if;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

`default_nettype wire

// File: rtl/dm_axi_master.sv
// ============================================================================
// Module      : dm_axi_master
// Description : CPU data-memory port to AXI bridge, one single-beat access at
//               a time. Define DM_AXI_ERR_EN to enable the sticky dm_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'd1
) (
    input  wire         ACLK,
    input  wire         ARESETn,
    input  wire         dm_on,
    input  wire  [31:0] dm_addr,
    input  wire  [31:0] dm_wdata,
    input  wire  [3:0]  dm_web,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        dm_err,
    dm_axi_if.master    axi
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_hs, w_hs;

    assign aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_hs  = axi.WVALID  && axi.WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            strb_q    <= 4'd0;
            rdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (dm_on) begin
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    strb_d    = ~dm_web;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (dm_web == 4'b1111) ? S_RADDR : S_WRITE;
                end
            end
            S_RADDR: begin
                if (axi.ARREADY) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (axi.RVALID) begin
                    rdata_d = axi.RDATA;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                // AW and W complete independently; leave once both have been seen.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (axi.BVALID) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = {addr_q[31:2], 2'b00};
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (state_q == S_RADDR);
    assign axi.RREADY  = (state_q == S_RDATA);

    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = (state_q == S_WRITE) && !aw_done_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = strb_q;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = (state_q == S_WRITE) && !w_done_q;
    assign axi.BREADY  = (state_q == S_WRESP);

    assign dm_rdata = rdata_q;

    // Gated by reset so the pipeline is released the instant reset asserts.
    assign dm_stall = ARESETn &&
                      (((state_q == S_IDLE) && dm_on) ||
                       (state_q inside {S_RADDR, S_RDATA, S_WRITE, S_WRESP}));

`ifdef DM_AXI_ERR_EN
    logic err_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q <= 1'b0;
        end else if (((state_q == S_RDATA) && axi.RVALID && (axi.RRESP != 2'b00)) ||
                     ((state_q == S_WRESP) && axi.BVALID && (axi.BRESP != 2'b00))) begin
            err_q <= 1'b1;
        end
    end

    assign dm_err = err_q;

    logic unused_axi;
    assign unused_axi = ^{axi.RID, axi.RLAST, axi.BID};
`else
    assign dm_err = 1'b0;

    logic unused_axi;
    assign unused_axi = ^{axi.RID, axi.RLAST, axi.BID, axi.RRESP, axi.BRESP};
`endif

endmodule

`default_nettype wire

// File: doc/dm_axi_master.md
DM_AXI_MASTER -- requirements
Module: dm_axi_master

Interface
REQ-001 The block SHALL have parameter MASTER_ID, default 4'd1, driven on ARID and AWID.
REQ-002 The block SHALL have port ACLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port ARESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port dm_on, input, 1 bit: CPU memory-stage access request.
REQ-005 The block SHALL have port dm_addr, input, 32 bits: byte address.
REQ-006 The block SHALL have port dm_wdata, input, 32 bits: store data, already lane-aligned by the CPU.
REQ-007 The block SHALL have port dm_web, input, 4 bits: active-low byte write enables; 4'b1111 means read.
REQ-008 The block SHALL have port dm_rdata, output, 32 bits: last read word.
REQ-009 The block SHALL have port dm_stall, output, 1 bit: freezes the CPU pipeline (DMstall_axi).
REQ-010 The block SHALL have port dm_err, output, 1 bit: sticky error flag.
REQ-011 The block SHALL have AR channel ports: ARID[3:0], ARADDR[31:0], ARLEN[3:0], ARSIZE[2:0], ARBURST[1:0] and ARVALID as outputs; ARREADY as input.
REQ-012 The block SHALL have R channel ports: RID[3:0], RDATA[31:0], RRESP[1:0], RLAST and RVALID as inputs; RREADY as output.
REQ-013 The block SHALL have AW channel ports: AWID, AWADDR, AWLEN, AWSIZE, AWBURST and AWVALID as outputs, with widths as AR; AWREADY as input.
REQ-014 The block SHALL have W channel ports: WDATA[31:0], WSTRB[3:0], WLAST and WVALID as outputs; WREADY as input.
REQ-015 The block SHALL have B channel ports: BID[3:0], BRESP[1:0] and BVALID as inputs; BREADY as output.

Function
REQ-016 The block SHALL issue single-beat transactions only, with LEN=0, SIZE=3'b010, BURST=INCR(2'b01) and WLAST=1.
REQ-017 The block SHALL implement FSM states IDLE, RADDR, RDATA, WRITE, WRESP and DONE.
REQ-018 In IDLE with dm_on=1, the FSM SHALL go to RADDR if dm_web==4'b1111, otherwise to WRITE; with dm_on=0 it SHALL stay in IDLE.
REQ-019 The block SHALL register the request (addr, wdata, strobe) on leaving IDLE and hold it until DONE.
REQ-020 In RADDR, ARVALID SHALL be 1 with ARADDR={addr[31:2],2'b00}, and the FSM SHALL go to RDATA on ARVALID&&ARREADY.
REQ-021 In RDATA, RREADY SHALL be 1; on RVALID the block SHALL latch RDATA into dm_rdata and go to DONE.
REQ-022 In WRITE, AWVALID and WVALID SHALL assert together, with WSTRB=~dm_web, WDATA=wdata and AWADDR=addr.
REQ-023 In WRITE, each channel SHALL drop its VALID after its own handshake; the FSM SHALL go to WRESP once both handshakes are done, whether they occur in the same or different cycles.
REQ-024 In WRESP, BREADY SHALL be 1, and the FSM SHALL go to DONE on BVALID.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE; a new request is not accepted while in DONE.
REQ-026 dm_stall SHALL be combinational: (state==IDLE && dm_on) || (state inside {RADDR, RDATA, WRITE, WRESP}); it is 0 in DONE so the pipeline advances exactly once per access.
REQ-027 dm_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-028 VALID signals, once asserted, SHALL stay asserted with stable payload until handshake.
REQ-029 Minimum latency SHALL be: read with ARREADY and RVALID both in the first possible cycle gives dm_stall high for 3 cycles, low on the 4th; write gives the same.

Reset
REQ-030 On ARESETn=0, the block SHALL immediately go to IDLE with all VALID/READY outputs 0, dm_rdata=0, dm_stall=0, dm_err=0 and the registered request cleared, including in the middle of a transaction.
REQ-031 After reset, the block SHALL ignore any AXI response still pending from the aborted transaction.

Configuration
REQ-032 With DM_AXI_ERR_EN defined, dm_err SHALL set when RRESP!=2'b00 on the read handshake or BRESP!=2'b00 on BVALID, and SHALL clear only on reset; the failing read still returns RDATA.
REQ-033 Without DM_AXI_ERR_EN, dm_err SHALL be tied to 0 and responses are not checked.

Verification
REQ-034 Read: dm_on=1, dm_web=4'hF, dm_addr=32'h0001_0006, slave always ready, RDATA=32'hDEAD_BEEF -> ARADDR=32'h0001_0004, dm_stall high for 3 cycles, dm_rdata=32'hDEAD_BEEF in DONE.
REQ-035 Byte write: dm_web=4'b1101, dm_wdata=32'h0000_AB00 -> WSTRB=4'b0010, AWVALID and WVALID in the same cycle, dm_stall low only after BVALID plus one cycle.
REQ-036 Skewed write: AWREADY 3 cycles late, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held stable, and exactly one B is awaited.
REQ-037 Back-to-back: a read then a write on consecutive requests -> one DONE cycle between them and no duplicate AR or AW.
REQ-038 Reset while in RDATA (ARESETn low for 2 cycles) -> all outputs 0 and state IDLE; a subsequent read completes normally.
REQ-039 With DM_AXI_ERR_EN, BRESP=2'b10 -> dm_err=1 and it stays 1 across later OKAY transactions; without the macro, dm_err stays 0.
